// File: rtl/katana_pkg.sv
// Shared constants, FSM encoding and averaging helpers for the katana centroid tracker.
package katana_pkg;

   localparam int H_ACTIVE   = 1024;
   localparam int V_ACTIVE   = 768;
   localparam int MIN_PIXELS = 16;
   localparam int ACC_W      = 30;
   localparam int CNT_W      = 20;
   localparam int X_W        = 11;
   localparam int Y_W        = 10;

   typedef logic [1:0] katana_state_t;

   localparam katana_state_t ST_ACCUM  = 2'd0;
   localparam katana_state_t ST_DIVIDE = 2'd1;
   localparam katana_state_t ST_DONE   = 2'd2;

   // Mean of two coordinates, summed one bit wider so the carry is kept.
   function automatic logic [X_W-1:0] half_sum_x(input logic [X_W-1:0] a, input logic [X_W-1:0] b);
      logic [X_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[X_W:1];
   endfunction

   function automatic logic [Y_W-1:0] half_sum_y(input logic [Y_W-1:0] a, input logic [Y_W-1:0] b);
      logic [Y_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[Y_W:1];
   endfunction

endpackage

// File: rtl/katana_tracker_seq_divider.sv
// Restoring divider producing one quotient bit per cycle; a start while idle loads the operands.
module seq_divider #(
   parameter int W = 30
) (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         start_i,
   input  logic [W-1:0] dividend_i,
   input  logic [W-1:0] divisor_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [W-1:0] quotient_o
);
   localparam int CW = $clog2(W + 1);

   logic [W-1:0]  rem_q, rem_d;
   logic [W-1:0]  quo_q, quo_d;
   logic [W-1:0]  div_q, div_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic [W:0]    shifted_s;

   // Next-state: one shift/trial-subtract step per busy cycle, or an operand load on start.
   always_comb begin
      shifted_s = {rem_q, quo_q[W-1]};
      rem_d     = rem_q;
      quo_d     = quo_q;
      div_d     = div_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      if (busy_q) begin
         if (shifted_s >= {1'b0, div_q}) begin
            rem_d = W'(shifted_s - {1'b0, div_q});
            quo_d = {quo_q[W-2:0], 1'b1};
         end else begin
            rem_d = shifted_s[W-1:0];
            quo_d = {quo_q[W-2:0], 1'b0};
         end
         if (cnt_q == CW'(1)) begin
            busy_d = 1'b0;
            cnt_d  = {CW{1'b0}};
         end else begin
            cnt_d  = cnt_q - CW'(1);
         end
      end else if (start_i) begin
         rem_d  = {W{1'b0}};
         quo_d  = dividend_i;
         div_d  = divisor_i;
         cnt_d  = CW'(W);
         busy_d = 1'b1;
      end else begin
         busy_d = 1'b0;
      end
   end

   // Divider state registers.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rem_q  <= {W{1'b0}};
         quo_q  <= {W{1'b0}};
         div_q  <= {W{1'b0}};
         cnt_q  <= {CW{1'b0}};
         busy_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         div_q  <= div_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   // done_o flags the final step; quotient_o is the value that step completes,
   // so the consumer can register it on that same edge.
   assign busy_o     = busy_q;
   assign done_o     = busy_q && (cnt_q == CW'(1));
   assign quotient_o = quo_d;

endmodule

// File: rtl/katana_tracker.sv
// Per-frame centroid of colour-masked pixels, presented stably until the next update.
// Build option: KATANA_SMOOTH_EN averages each present update with the previous present output.
module katana_tracker
   import katana_pkg::*;
(
   input  logic           clk_in,
   input  logic           rst_in,
   input  logic [10:0]    hcount_in,
   input  logic [9:0]     vcount_in,
   input  logic           mask_in,
   output logic [10:0]    katana_x,
   output logic [9:0]     katana_y,
   output logic           katana_present,
   output logic           katana_valid,
   output logic           busy
);
   logic [ACC_W-1:0] sum_x_q, sum_y_q;
   logic [CNT_W-1:0] cnt_q;
   katana_state_t    state_q, state_d;
   logic [X_W-1:0]   katana_x_q, katana_x_d, upd_x_s;
   logic [Y_W-1:0]   katana_y_q, katana_y_d, upd_y_s;
   logic             present_q, present_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             in_active_s, frame_end_s, start_s;
   logic             div_busy_x_s, div_busy_y_s, div_done_x_s, div_done_y_s;
   logic [ACC_W-1:0] quo_x_s, quo_y_s;
   logic [ACC_W-1:0] divisor_s;
   logic             unused_quo_s;

   assign in_active_s = (hcount_in < 11'(H_ACTIVE)) && (vcount_in < 10'(V_ACTIVE));
   assign frame_end_s = (hcount_in == 11'(H_ACTIVE)) && (vcount_in == 10'(V_ACTIVE));
   assign start_s     = frame_end_s && (state_q == ST_ACCUM) && (cnt_q >= CNT_W'(MIN_PIXELS))
                        && !div_busy_x_s && !div_busy_y_s;
   assign divisor_s   = {{(ACC_W-CNT_W){1'b0}}, cnt_q};

   // Frame accumulators; frame_end is a blanking pixel so clearing never collides with an add.
   always_ff @(posedge clk_in) begin
      if (rst_in || frame_end_s) begin
         sum_x_q <= {ACC_W{1'b0}};
         sum_y_q <= {ACC_W{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
      end else if (in_active_s && mask_in) begin
         sum_x_q <= sum_x_q + ACC_W'(hcount_in);
         sum_y_q <= sum_y_q + ACC_W'(vcount_in);
         cnt_q   <= cnt_q + CNT_W'(1);
      end else begin
         sum_x_q <= sum_x_q;
         sum_y_q <= sum_y_q;
         cnt_q   <= cnt_q;
      end
   end

   seq_divider #(.W(ACC_W)) u_div_x (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .start_i    (start_s),
      .dividend_i (sum_x_q),
      .divisor_i  (divisor_s),
      .busy_o     (div_busy_x_s),
      .done_o     (div_done_x_s),
      .quotient_o (quo_x_s)
   );

   seq_divider #(.W(ACC_W)) u_div_y (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .start_i    (start_s),
      .dividend_i (sum_y_q),
      .divisor_i  (divisor_s),
      .busy_o     (div_busy_y_s),
      .done_o     (div_done_y_s),
      .quotient_o (quo_y_s)
   );

   // Quotients never exceed the active area, so the upper bits are always zero.
   assign unused_quo_s = ^{quo_x_s[ACC_W-1:X_W], quo_y_s[ACC_W-1:Y_W]};

   // Coordinate written on a present update.
   always_comb begin
`ifdef KATANA_SMOOTH_EN
      if (present_q) begin
         upd_x_s = half_sum_x(katana_x_q, quo_x_s[X_W-1:0]);
         upd_y_s = half_sum_y(katana_y_q, quo_y_s[Y_W-1:0]);
      end else begin
         upd_x_s = quo_x_s[X_W-1:0];
         upd_y_s = quo_y_s[Y_W-1:0];
      end
`else
      upd_x_s = quo_x_s[X_W-1:0];
      upd_y_s = quo_y_s[Y_W-1:0];
`endif
   end

   // FSM next-state and output update; snapshots arriving outside ACCUM are dropped.
   always_comb begin
      state_d    = state_q;
      katana_x_d = katana_x_q;
      katana_y_d = katana_y_q;
      present_d  = present_q;
      valid_d    = 1'b0;
      busy_d     = busy_q;
      case (state_q)
         ST_ACCUM: begin
            if (start_s) begin
               state_d = ST_DIVIDE;
               busy_d  = 1'b1;
            end else if (frame_end_s) begin
               state_d   = ST_DONE;
               present_d = 1'b0;
               valid_d   = 1'b1;
            end else begin
               state_d = ST_ACCUM;
            end
         end
         ST_DIVIDE: begin
            if (div_done_x_s && div_done_y_s) begin
               state_d    = ST_DONE;
               busy_d     = 1'b0;
               katana_x_d = upd_x_s;
               katana_y_d = upd_y_s;
               present_d  = 1'b1;
               valid_d    = 1'b1;
            end else begin
               state_d = ST_DIVIDE;
            end
         end
         ST_DONE: begin
            state_d = ST_ACCUM;
         end
         default: begin
            state_d = ST_ACCUM;
            busy_d  = 1'b0;
         end
      endcase
   end

   // FSM and output registers.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= ST_ACCUM;
         katana_x_q <= {X_W{1'b0}};
         katana_y_q <= {Y_W{1'b0}};
         present_q  <= 1'b0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         katana_x_q <= katana_x_d;
         katana_y_q <= katana_y_d;
         present_q  <= present_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
      end
   end

   assign katana_x       = katana_x_q;
   assign katana_y       = katana_y_q;
   assign katana_present = present_q;
   assign katana_valid   = valid_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_katana_tracker.sv
// Directed and randomized frames checked against an arithmetic centroid model.
module tb_katana_tracker;
   localparam int ACC_W   = 30;
   localparam int MIN_PIX = 16;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [10:0] hcount_in;
   logic [9:0]  vcount_in;
   logic        mask_in;
   logic [10:0] katana_x;
   logic [9:0]  katana_y;
   logic        katana_present;
   logic        katana_valid;
   logic        busy;

   katana_tracker dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .hcount_in      (hcount_in),
      .vcount_in      (vcount_in),
      .mask_in        (mask_in),
      .katana_x       (katana_x),
      .katana_y       (katana_y),
      .katana_present (katana_present),
      .katana_valid   (katana_valid),
      .busy           (busy)
   );

   always #5 clk_in = ~clk_in;

   int checks = 0;
   int errors = 0;

   // Model: running sums of the current frame and the expected visible outputs.
   longint m_sx = 0, m_sy = 0;
   int     m_cnt = 0;
   int     exp_x = 0, exp_y = 0, exp_p = 0;
   int     pend_x, pend_y, pend_p, pend_lat;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic step(input int h, input int v, input bit m);
      hcount_in = 11'(h);
      vcount_in = 10'(v);
      mask_in   = m;
      if (m && h < 1024 && v < 768 && !rst_in) begin
         m_sx  += h;
         m_sy  += v;
         m_cnt += 1;
      end
      @(posedge clk_in);
      #1;
   endtask

   task automatic close_frame();
      int nx, ny;
      if (m_cnt >= MIN_PIX) begin
         nx = int'(m_sx / m_cnt);
         ny = int'(m_sy / m_cnt);
`ifdef KATANA_SMOOTH_EN
         if (exp_p != 0) begin
            nx = (exp_x + nx) / 2;
            ny = (exp_y + ny) / 2;
         end
`endif
         pend_x = nx; pend_y = ny; pend_p = 1; pend_lat = ACC_W + 1;
      end else begin
         pend_x = exp_x; pend_y = exp_y; pend_p = 0; pend_lat = 1;
      end
      m_sx = 0; m_sy = 0; m_cnt = 0;
      step(1024, 768, 1'b0);
   endtask

   task automatic wait_result(input string tag, input int n0);
      int n = n0;
      int busy_cyc = 0;
      int unstable = 0;
      while (katana_valid !== 1'b1 && n < 100) begin
         if (busy === 1'b1) busy_cyc++;
         if (katana_x !== 11'(exp_x) || katana_y !== 10'(exp_y) || katana_present !== 1'(exp_p))
            unstable++;
         step(1030, 0, 1'b0);
         n++;
      end
      check({tag, "_latency"}, n, pend_lat);
      check({tag, "_busy_cycles"}, busy_cyc, (pend_lat > 1) ? pend_lat - n0 : 0);
      check({tag, "_hold_while_waiting"}, unstable, 0);
      check({tag, "_busy_at_valid"}, busy, 0);
      check({tag, "_x"}, katana_x, pend_x);
      check({tag, "_y"}, katana_y, pend_y);
      check({tag, "_present"}, katana_present, pend_p);
      exp_x = pend_x; exp_y = pend_y; exp_p = pend_p;
      step(1030, 0, 1'b0);
      check({tag, "_valid_one_cycle"}, katana_valid, 0);
      check({tag, "_x_stable"}, katana_x, exp_x);
   endtask

   task automatic block(input int x0, input int y0, input int w, input int h);
      for (int j = 0; j < h; j++)
         for (int i = 0; i < w; i++)
            step(x0 + i, y0 + j, 1'b1);
   endtask

   initial begin
      int vpulses;
      rst_in = 1'b1;
      for (int i = 0; i < 3; i++) step(1030, 0, 1'b0);
      check("rst_x", katana_x, 0);
      check("rst_y", katana_y, 0);
      check("rst_present", katana_present, 0);
      check("rst_valid", katana_valid, 0);
      check("rst_busy", busy, 0);
      rst_in = 1'b0;
      step(1030, 0, 1'b0);

      close_frame();
      wait_result("empty", 1);

      block(100, 200, 4, 4);
      close_frame();
      wait_result("block16", 1);

      for (int i = 0; i < 15; i++) step(300 + i, 50, 1'b1);
      close_frame();
      wait_result("sparse15", 1);

      block(1020, 764, 4, 4);
      step(1030, 764, 1'b1);
      step(1024, 100, 1'b1);
      step(10, 768, 1'b1);
      close_frame();
      wait_result("corner", 1);

      // A second frame_end mid-division: in-flight result must be unaffected.
      block(600, 400, 4, 5);
      close_frame();
      step(10, 10, 1'b1);
      step(11, 10, 1'b1);
      step(12, 10, 1'b1);
      m_sx = 0; m_sy = 0; m_cnt = 0;
      step(1024, 768, 1'b0);
      wait_result("fe_in_divide", 5);
      close_frame();
      wait_result("after_discard", 1);

      // Reset ten cycles into a division.
      block(40, 60, 4, 4);
      close_frame();
      for (int i = 0; i < 9; i++) step(700 + i, 20, 1'b1);
      rst_in = 1'b1;
      step(1030, 0, 1'b0);
      check("midrst_x", katana_x, 0);
      check("midrst_y", katana_y, 0);
      check("midrst_present", katana_present, 0);
      check("midrst_valid", katana_valid, 0);
      check("midrst_busy", busy, 0);
      rst_in = 1'b0;
      m_sx = 0; m_sy = 0; m_cnt = 0;
      exp_x = 0; exp_y = 0; exp_p = 0;
      vpulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (katana_valid === 1'b1) vpulses++;
         step(1030, 0, 1'b0);
      end
      check("midrst_no_stale_valid", vpulses, 0);
      block(499, 299, 4, 4);
      close_frame();
      wait_result("post_reset_500_300", 1);

      for (int f = 0; f < 6; f++) begin
         int npx, x0, y0;
         npx = $urandom_range(10, 30);
         x0  = $urandom_range(0, 1000);
         y0  = $urandom_range(0, 740);
         for (int p = 0; p < npx; p++) begin
            step(x0 + $urandom_range(0, 23), y0 + $urandom_range(0, 27), 1'b1);
            if ($urandom_range(0, 3) == 0)
               step(1024 + $urandom_range(0, 100), $urandom_range(0, 767), 1'b1);
            if ($urandom_range(0, 5) == 0)
               step($urandom_range(0, 1023), 768 + $urandom_range(1, 50), 1'b1);
         end
         close_frame();
         wait_result($sformatf("rand%0d", f), 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
